// File: rtl/rom_load_sequencer.sv
// Sequences HPS ioctl downloads into the TropicalAngel core: ROM bytes go to the dn_* bus,
// DIP bytes land in sw0/sw1, and the core is held in reset until the load settles.
module rom_load_sequencer #(
   parameter logic [16:0] EXPECTED_BYTES = 17'h1C000,
   parameter int unsigned RESET_HOLD     = 16,
   parameter logic [7:0]  DIP0_DEFAULT   = 8'hFF,
   parameter logic [7:0]  DIP1_DEFAULT   = 8'hFF
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   input  logic [7:0]  ioctl_index,
   output logic [16:0] dn_addr,
   output logic [7:0]  dn_data,
   output logic        dn_wr,
   output logic [7:0]  sw0,
   output logic [7:0]  sw1,
   output logic        core_reset,
   output logic        load_ok,
   output logic        load_err
);

   typedef enum logic [2:0] {IDLE, LOAD_ROM, LOAD_DIP, HOLD, RUN} state_t;

   localparam logic [17:0] CNT_MAX      = 18'h20000;
   localparam logic [17:0] EXPECTED_CNT = {1'b0, EXPECTED_BYTES};
   localparam logic [7:0]  HOLD_LAST    = 8'(RESET_HOLD - 1);

   state_t      state_q, state_d;
   logic        wrPrev_q, dlPrev_q;
   logic [17:0] byteCnt_q, byteCnt_d;
   logic [7:0]  holdCnt_q, holdCnt_d;
   logic        rangeErr_q, rangeErr_d;
   logic        loadOk_q, loadOk_d;
   logic        loadErr_q, loadErr_d;
   logic [16:0] dnAddr_q, dnAddr_d;
   logic [7:0]  dnData_q, dnData_d;
   logic        dnWr_q, dnWr_d;
   logic [7:0]  sw0_q, sw0_d;
   logic [7:0]  sw1_q, sw1_d;

   logic dlRise, dlFall, wrAccept, inRange, isRom, isDip;

   // A write on the very cycle the download drops still belongs to that download.
   assign dlRise   = ioctl_download & ~dlPrev_q;
   assign dlFall   = ~ioctl_download & dlPrev_q;
   assign wrAccept = ioctl_wr & ~wrPrev_q & (ioctl_download | dlPrev_q);
   assign inRange  = (ioctl_addr[24:17] == 8'd0);
   assign isRom    = (ioctl_index == 8'd0);
   assign isDip    = (ioctl_index == 8'd254);

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q    <= IDLE;
         wrPrev_q   <= 1'b0;
         dlPrev_q   <= 1'b0;
         byteCnt_q  <= '0;
         holdCnt_q  <= '0;
         rangeErr_q <= 1'b0;
         loadOk_q   <= 1'b0;
         loadErr_q  <= 1'b0;
         dnAddr_q   <= '0;
         dnData_q   <= '0;
         dnWr_q     <= 1'b0;
         sw0_q      <= DIP0_DEFAULT;
         sw1_q      <= DIP1_DEFAULT;
      end else begin
         state_q    <= state_d;
         wrPrev_q   <= ioctl_wr;
         dlPrev_q   <= ioctl_download;
         byteCnt_q  <= byteCnt_d;
         holdCnt_q  <= holdCnt_d;
         rangeErr_q <= rangeErr_d;
         loadOk_q   <= loadOk_d;
         loadErr_q  <= loadErr_d;
         dnAddr_q   <= dnAddr_d;
         dnData_q   <= dnData_d;
         dnWr_q     <= dnWr_d;
         sw0_q      <= sw0_d;
         sw1_q      <= sw1_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      byteCnt_d  = byteCnt_q;
      holdCnt_d  = holdCnt_q;
      rangeErr_d = rangeErr_q;
      loadOk_d   = loadOk_q;
      loadErr_d  = loadErr_q;
      dnAddr_d   = dnAddr_q;
      dnData_d   = dnData_q;
      dnWr_d     = 1'b0;
      sw0_d      = sw0_q;
      sw1_d      = sw1_q;
      core_reset = 1'b1;

      case (state_q)
         IDLE: begin
            if (dlRise && isRom) begin
               state_d    = LOAD_ROM;
               byteCnt_d  = '0;
               rangeErr_d = 1'b0;
               loadOk_d   = 1'b0;
               loadErr_d  = 1'b0;
            end else if (dlRise && isDip) begin
               state_d = LOAD_DIP;
            end else if (dlFall) begin
               state_d   = HOLD;
               holdCnt_d = '0;
            end else if (!ioctl_download) begin
               state_d = RUN;
            end
         end

         LOAD_ROM: begin
            if (wrAccept) begin
               if (inRange) begin
                  dnAddr_d = ioctl_addr[16:0];
                  dnData_d = ioctl_dout;
                  dnWr_d   = 1'b1;
                  if (byteCnt_q != CNT_MAX) begin
                     byteCnt_d = byteCnt_q + 18'd1;
                  end
               end else begin
                  rangeErr_d = 1'b1;
               end
            end
            // Size check uses the updated count so a final byte on the falling edge is included.
            if (dlFall) begin
               state_d   = HOLD;
               holdCnt_d = '0;
               loadOk_d  = (byteCnt_d == EXPECTED_CNT) && !rangeErr_d;
               loadErr_d = !loadOk_d;
            end
         end

         LOAD_DIP: begin
            if (wrAccept) begin
               if (ioctl_addr == 25'd0) begin
                  sw0_d = ioctl_dout;
               end else if (ioctl_addr == 25'd1) begin
                  sw1_d = ioctl_dout;
               end
            end
            if (dlFall) begin
               state_d   = HOLD;
               holdCnt_d = '0;
            end
         end

         HOLD: begin
            if (dlRise && isRom) begin
               state_d    = LOAD_ROM;
               holdCnt_d  = '0;
               byteCnt_d  = '0;
               rangeErr_d = 1'b0;
               loadOk_d   = 1'b0;
               loadErr_d  = 1'b0;
            end else if (dlRise && isDip) begin
               state_d   = LOAD_DIP;
               holdCnt_d = '0;
            end else if (holdCnt_q == HOLD_LAST) begin
               state_d = RUN;
            end else begin
               holdCnt_d = holdCnt_q + 8'd1;
            end
         end

         RUN: begin
            core_reset = 1'b0;
            if (dlRise && isRom) begin
               state_d    = LOAD_ROM;
               core_reset = 1'b1;
               byteCnt_d  = '0;
               rangeErr_d = 1'b0;
               loadOk_d   = 1'b0;
               loadErr_d  = 1'b0;
            end else if (dlRise && isDip) begin
               state_d    = LOAD_DIP;
               core_reset = 1'b1;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   assign dn_addr  = dnAddr_q;
   assign dn_data  = dnData_q;
   assign dn_wr    = dnWr_q;
   assign sw0      = sw0_q;
   assign sw1      = sw1_q;
   assign load_ok  = loadOk_q;
   assign load_err = loadErr_q;

endmodule

// File: doc/rom_load_sequencer.md
Name: rom_load_sequencer

Overview:
- Sits between the HPS ioctl download stream and the TropicalAngel core; it sequences each download.
- Routes ROM bytes (index 0) onto the core's dn_* write bus and captures DIP bytes (index 254) into the two switch registers.
- Holds the core in reset during a download and for a fixed tail afterwards, then reports whether the image size was correct.

Parameters:
- EXPECTED_BYTES, 17'h1C000: exact ROM byte count required for load_ok.
- RESET_HOLD, 16: clk_sys cycles that core_reset stays high after the download ends (range 1..255).
- DIP0_DEFAULT, 8'hFF: sw0 value after reset.
- DIP1_DEFAULT, 8'hFF: sw1 value after reset.

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ioctl_download  in  1  download active.
- ioctl_wr  in  1  byte strobe.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- ioctl_index  in  8  0 = ROM, 254 = DIP, others ignored.
- dn_addr  out  17  ROM write address to the core.
- dn_data  out  8  ROM write data.
- dn_wr  out  1  single-cycle ROM write strobe.
- sw0  out  8  DIP bank 1.
- sw1  out  8  DIP bank 2.
- core_reset  out  1  reset to the core.
- load_ok  out  1  last ROM download had exactly EXPECTED_BYTES bytes and no range error.
- load_err  out  1  last ROM download was short, long, or out of range.

Behaviour:
- Reset values:
  - dn_addr = 0, dn_data = 0, dn_wr = 0.
  - sw0 = DIP0_DEFAULT, sw1 = DIP1_DEFAULT.
  - core_reset = 1, load_ok = 0, load_err = 0.
  - State = IDLE, byte counter = 0, hold counter = 0.
- Strobe qualification: only a 0->1 edge of ioctl_wr is a write (registered previous value). A strobe held high N cycles produces one write.
- FSM states: IDLE, LOAD_ROM, LOAD_DIP, HOLD, RUN.
- IDLE:
  - core_reset = 1.
  - ioctl_download rising with index 0 -> LOAD_ROM; clear byte counter, load_ok, load_err.
  - ioctl_download rising with index 254 -> LOAD_DIP.
  - With download low -> RUN after one cycle.
  - Any other index: stay IDLE until download falls, then -> HOLD.
- LOAD_ROM:
  - core_reset = 1.
  - Qualified write with ioctl_addr < 2^17: dn_addr = ioctl_addr[16:0], dn_data = ioctl_dout, dn_wr = 1 for exactly one cycle, one cycle after the qualified edge. Byte counter +1, saturating at 2^17.
  - Write with ioctl_addr >= 2^17: no dn_wr; set the sticky range-error flag.
  - dn_addr/dn_data hold their last value between writes.
  - Download falls -> HOLD. On that cycle: load_ok = (count == EXPECTED_BYTES) and no range error; load_err = !load_ok.
- LOAD_DIP:
  - core_reset = 1.
  - Write at addr 0 -> sw0; addr 1 -> sw1; other addresses ignored.
  - dn_wr never asserts.
  - Download falls -> HOLD. load_ok and load_err are unchanged.
- HOLD:
  - core_reset = 1; hold counter counts 0..RESET_HOLD-1, then -> RUN.
  - Download rising during HOLD -> re-enter the matching LOAD state; hold counter clears.
- RUN:
  - core_reset = 0.
  - Download rising -> LOAD_ROM or LOAD_DIP per index, with core_reset = 1 the same cycle as the transition.
  - Writes while the download is low are ignored in every state.
- Simultaneous events:
  - reset overrides everything.
  - Write strobe on the cycle the download falls is still accepted and counted before the size check.
- Reset mid-download: all state returns to reset values, including sw0/sw1. The core stays in reset until a fresh sequence completes or download is low → IDLE → RUN.
- Latency: ioctl_wr edge to dn_wr = 1 cycle; download fall to core_reset low = RESET_HOLD + 1 cycles.

Test Plan:
- Reset, download low -> core_reset low on cycle 2 after reset release; sw0 = sw1 = 8'hFF; load_ok = load_err = 0.
- Index 0, 0x1C000 byte pulses, addr incrementing, data = addr[7:0] -> 0x1C000 dn_wr pulses, each 1 cycle after its strobe, with matching addr/data; on fall load_ok = 1; core_reset low exactly 17 cycles after the fall.
- Index 0, 0x1BFFF bytes -> load_err = 1, load_ok = 0. Then a repeat with one write at addr 0x1FFFF plus one at 0x20000 -> 0x20000 suppressed (no dn_wr), load_err = 1.
- Index 254, bytes 0xA5 @0, 0x3C @1, 0x77 @2 -> sw0 = A5, sw1 = 3C; dn_wr never high; load flags unchanged.
- ioctl_wr held high 5 cycles -> exactly one dn_wr; strobe with download low -> no dn_wr.
- reset pulsed after 100 ROM bytes -> all outputs at reset values next cycle; a following 0x1C000-byte load gives load_ok = 1.
